scan_write_ctrl: RTL and testbench

SCAN_WRITE_CTRL -- requirements
Module: scan_write_ctrl

---
 rtl/scan_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/scan_write_ctrl.sv | 159 +++++++++++++++
 tb/tb_scan_write_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan write controller: FSM state encoding and
// default frame geometry, FIFO depth and counter widths.
package scan_pkg;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;
    localparam int X_W_DEF   = 8;
    localparam int Y_W_DEF   = 8;
    localparam int CH_W_DEF  = 3;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read, synchronous flush and
// full/empty flags. DEPTH must be a power of two.
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/scan_write_ctrl.sv
// Accepts a raster-ordered pixel stream, buffers it, and issues one framebuffer
// write per pixel with its x/y coordinate; reports frame completion and duration.
module scan_write_ctrl
    import scan_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int CH_W  = CH_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mono,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_r,
    input  logic [CH_W-1:0]  in_g,
    input  logic [CH_W-1:0]  in_b,
    output logic             in_ready,
    input  logic             fb_ready,
    output logic             write_en,
    output logic [X_W-1:0]   write_x,
    output logic [Y_W-1:0]   write_y,
    output logic [CH_W-1:0]  write_r,
    output logic [CH_W-1:0]  write_g,
    output logic [CH_W-1:0]  write_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int               PIX_TOTAL_INT = IMG_W * IMG_H;
    localparam int               ACC_W         = $clog2(PIX_TOTAL_INT + 1);
    localparam int               DATA_W        = 3 * CH_W;
    localparam logic [ACC_W-1:0] PIX_TOTAL     = ACC_W'(PIX_TOTAL_INT);
    localparam logic [ACC_W-1:0] PIX_LAST      = ACC_W'(PIX_TOTAL_INT - 1);
    localparam logic [X_W-1:0]   X_LAST        = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST        = Y_W'(IMG_H - 1);

    state_t            state;
    state_t            state_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [ACC_W-1:0]  accepted;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic              mono_lat;
    logic              start_ok;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_din;
    logic [DATA_W-1:0] fifo_dout;

    assign start_ok = (state == IDLE) && start && !abort;
    assign in_ready = (state == RUN) && !fifo_full && (accepted != PIX_TOTAL)
                      && !abort && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && fb_ready && !abort;
    assign last_pop = pop && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign fifo_din = mono_lat ? {in_r, in_r, in_r} : {in_r, in_g, in_b};

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (abort),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (push && (accepted == PIX_LAST)) state_nxt = DRAIN;
                DRAIN:   if (last_pop) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            accepted    <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            mono_lat    <= 1'b0;
            write_en    <= 1'b0;
            write_x     <= '0;
            write_y     <= '0;
            write_r     <= '0;
            write_g     <= '0;
            write_b     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            busy     <= busy_nxt;
            done     <= done_nxt;
            write_en <= pop;

            if (pop) begin
                write_x                       <= x_cnt;
                write_y                       <= y_cnt;
                {write_r, write_g, write_b}   <= fifo_dout;
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end

            if (push) accepted <= accepted + 1'b1;

            // The start edge is the frame's first counted cycle, so the
            // count reads its final value during DONE alongside the done pulse.
            if (start_ok) begin
                accepted    <= '0;
                x_cnt       <= '0;
                y_cnt       <= '0;
                mono_lat    <= mono;
                cycle_count <= CNT_W'(1);
            end else if ((state_nxt inside {RUN, DRAIN, DONE}) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_write_ctrl.sv
// Self-checking bench for scan_write_ctrl at a 4x2 frame with a 4-entry FIFO,
// using a transaction-level reference model (pixel queue plus raster index).
module tb_scan_write_ctrl;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int N   = W * H;
    localparam int CH  = 3;
    localparam int CW  = 24;
    localparam int DEP = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          mono;
    logic          in_valid;
    logic          fb_ready;
    logic [CH-1:0] in_r;
    logic [CH-1:0] in_g;
    logic [CH-1:0] in_b;
    logic          in_ready;
    logic          write_en;
    logic [7:0]    write_x;
    logic [7:0]    write_y;
    logic [CH-1:0] write_r;
    logic [CH-1:0] write_g;
    logic [CH-1:0] write_b;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;

    scan_write_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .X_W   (8),
        .Y_W   (8),
        .CH_W  (CH),
        .DEPTH (DEP),
        .CNT_W (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .mono        (mono),
        .in_valid    (in_valid),
        .in_r        (in_r),
        .in_g        (in_g),
        .in_b        (in_b),
        .in_ready    (in_ready),
        .fb_ready    (fb_ready),
        .write_en    (write_en),
        .write_x     (write_x),
        .write_y     (write_y),
        .write_r     (write_r),
        .write_g     (write_g),
        .write_b     (write_b),
        .busy        (busy),
        .done        (done),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3*CH-1:0] rgb;
        int              xcyc;
    } pix_t;

    pix_t            exp_q[$];
    int              n_pass    = 0;
    int              n_total   = 0;
    int              cyc       = 0;
    int              start_cyc = 0;
    int              n_wr      = 0;
    int              n_xfer    = 0;
    int              n_done    = 0;
    int              cc_hold   = 0;
    bit              model_idle   = 1'b1;
    bit              active       = 1'b0;
    bit              done_pending = 1'b0;
    bit              mono_m       = 1'b0;
    bit              exact_lat    = 1'b0;
    logic [3*CH-1:0] first_rgb    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rand_pix();
        in_r = CH'($urandom);
        in_g = CH'($urandom);
        in_b = CH'($urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_write_en"}, write_en, 0);
        check({tag, "_write_x"}, write_x, 0);
        check({tag, "_write_y"}, write_y, 0);
        check({tag, "_write_rgb"}, {write_r, write_g, write_b}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    // One clock cycle: sample the handshake before the edge, advance the
    // model at the edge, then compare registered outputs after the edge.
    task automatic tick();
        logic            xfer;
        logic            wrote;
        logic [3*CH-1:0] px;
        pix_t            p;
        int              exp_cc;
        #1;
        xfer = in_valid && in_ready;
        if (reset || abort) check("in_ready_forced_low", in_ready, 0);
        px = mono_m ? {in_r, in_r, in_r} : {in_r, in_g, in_b};
        @(posedge clock);
        cyc++;
        if (reset) begin
            exp_q.delete();
            model_idle   = 1'b1;
            active       = 1'b0;
            done_pending = 1'b0;
            cc_hold      = 0;
        end else if (abort) begin
            if (active) cc_hold = cyc - start_cyc;
            exp_q.delete();
            model_idle   = 1'b1;
            active       = 1'b0;
            done_pending = 1'b0;
        end else if (done_pending) begin
            model_idle   = 1'b1;
            done_pending = 1'b0;
        end else if (model_idle && start) begin
            model_idle = 1'b0;
            active     = 1'b1;
            mono_m     = mono;
            start_cyc  = cyc;
            n_wr       = 0;
            n_xfer     = 0;
        end
        if (!reset && !abort && xfer === 1'b1) begin
            exp_q.push_back('{rgb: px, xcyc: cyc});
            n_xfer++;
        end

        #1;
        wrote = (write_en === 1'b1);
        if (wrote) begin
            if (exp_q.size() == 0) begin
                check("spurious_write_en", write_en, 0);
            end else begin
                p = exp_q.pop_front();
                check("write_x", write_x, n_wr % W);
                check("write_y", write_y, n_wr / W);
                check("write_rgb", {write_r, write_g, write_b}, p.rgb);
                if (exact_lat) check("latency_exact", cyc - p.xcyc + 1, 2);
                else           check("latency_min", (cyc - p.xcyc + 1) >= 2, 1);
                if (n_wr == 0) first_rgb = {write_r, write_g, write_b};
                n_wr++;
            end
        end
        exp_cc = active ? (cyc - start_cyc + 1) : cc_hold;
        if (active && wrote && n_wr == N) begin
            active       = 1'b0;
            done_pending = 1'b1;
            cc_hold      = exp_cc;
            n_done++;
            check("done_pulse", done, 1);
        end else begin
            check("done_low", done, 0);
        end
        check("busy", busy, active);
        check("cycle_count", cycle_count, exp_cc);
        @(negedge clock);
    endtask

    task automatic run_to_done(input string tag, input int pv, input int pf, input int budget);
        int d0 = n_done;
        int k  = 0;
        while (n_done == d0 && k < budget) begin
            in_valid = ($urandom_range(0, 99) < pv);
            fb_ready = ($urandom_range(0, 99) < pf);
            rand_pix();
            tick();
            k++;
        end
        check(tag, n_done - d0, 1);
        in_valid = 1'b0;
        fb_ready = 1'b0;
        tick();
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mono = 1'b0;
        in_valid = 1'b0; fb_ready = 1'b0; in_r = '0; in_g = '0; in_b = '0;
        tick();
        tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Nominal frame: everything held high.
        exact_lat = 1'b1;
        start = 1'b1; in_valid = 1'b1; fb_ready = 1'b1; rand_pix();
        tick();
        start = 1'b0;
        run_to_done("nominal_done", 100, 100, 30);
        check("nominal_write_count", n_wr, N);
        check("nominal_cycle_count", cycle_count, 10);
        exact_lat = 1'b0;
        repeat (3) tick();

        // Backpressure: framebuffer stalled for 10 cycles.
        start = 1'b1; in_valid = 1'b1; fb_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_pix();
            tick();
        end
        check("bp_transfers", n_xfer, DEP);
        check("bp_no_write", n_wr, 0);
        check("bp_in_ready_low", in_ready, 0);
        run_to_done("bp_done", 100, 100, 40);

        // Mono: red replicated into all channels; mono changes after start are ignored.
        mono = 1'b1; start = 1'b1; in_valid = 1'b0; fb_ready = 1'b1;
        tick();
        start = 1'b0; mono = 1'b0;
        in_valid = 1'b1; in_r = 3'd5; in_g = 3'd2; in_b = 3'd7;
        tick();
        check("mono_first_xfer", n_xfer, 1);
        run_to_done("mono_done", 80, 80, 100);
        check("mono_first_rgb", first_rgb, 9'o555);

        // Abort right after the third write.
        start = 1'b1; in_valid = 1'b1; fb_ready = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (n_wr < 3 && k < 20) begin
            rand_pix();
            tick();
            k++;
        end
        check("abort_third_write_seen", n_wr, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_low", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_write_en", write_en, 0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done("after_abort_done", 100, 100, 30);
        check("after_abort_write_count", n_wr, N);

        // Mid-frame reset, then a start while running is ignored.
        start = 1'b1; in_valid = 1'b1; fb_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) begin
            rand_pix();
            tick();
        end
        reset = 1'b1;
        tick();
        check_outputs_zero("midreset");
        reset = 1'b0; in_valid = 1'b0;
        tick();
        start = 1'b1; in_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) begin
            rand_pix();
            tick();
        end
        start = 1'b1;
        rand_pix();
        tick();
        start = 1'b0;
        check("restart_ignored_busy", busy, 1);
        run_to_done("midreset_done", 100, 100, 30);
        check("midreset_write_count", n_wr, N);

        // Randomized frames with random handshake activity.
        for (int f = 0; f < 3; f++) begin
            mono = 1'($urandom_range(0, 1)); start = 1'b1; in_valid = 1'b0;
            tick();
            start = 1'b0;
            run_to_done("random_done", $urandom_range(30, 90), $urandom_range(30, 90), 400);
            check("random_write_count", n_wr, N);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
